nthband_param_sequencer: RTL and testbench
==========================================

Name: nthband_param_sequencer

Overview:
- Per-block parameter scheduler for the nth-band predictor.
- Accepts one alpha / xmean / xhatmean triple per block, then replays each value on its own output stream exactly 2^BLOCK_SIZE_LOG times, one per xhat sample the predictor consumes.
- Sits between the coefficient/mean calculators and the nthband_predictor parameter inputs.
- Each output channel is drained independently, so predictor-side join skew cannot deadlock the block.

Parameters:
- DATA_WIDTH, 16, width of xmean and xhatmean.
- ALPHA_WIDTH, 10, width of alpha.
- BLOCK_SIZE_LOG, 8, log2 of samples per block; N = 2^BLOCK_SIZE_LOG repetitions.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- alpha_in_valid / alpha_in_ready  in / out  1  alpha source handshake.
- alpha_in_data  in  ALPHA_WIDTH  alpha for the next block.
- xmean_in_valid / xmean_in_ready  in / out  1  xmean source handshake.
- xmean_in_data  in  DATA_WIDTH  xmean for the next block.
- xhatmean_in_valid / xhatmean_in_ready  in / out  1  xhatmean source handshake.
- xhatmean_in_data  in  DATA_WIDTH  xhatmean for the next block.
- alpha_valid / alpha_ready  out / in  1  alpha output handshake to the predictor.
- alpha_data  out  ALPHA_WIDTH  held alpha.
- alpha_last  out  1  high on the Nth alpha repetition.
- xmean_valid / xmean_ready / xmean_data / xmean_last  out / in / out / out  1 / 1 / DATA_WIDTH / 1  same scheme for xmean.
- xhatmean_valid / xhatmean_ready / xhatmean_data / xhatmean_last  out / in / out / out  1 / 1 / DATA_WIDTH / 1  same scheme for xhatmean.
- block_done  out  1  one-cycle pulse when all three channels have finished a block.

Behaviour:
- Reset (asynchronous, active-high): state=LOAD; all three counters=0; param registers=0; every *_valid, *_in_ready, *_last and block_done=0. Reset mid-block abandons the block; nothing is replayed after reset.
- Handshake: transfer occurs when valid&ready are both high on a rising edge. Outputs are registered-state driven; output valid never depends combinationally on output ready.
- LOAD:
  - All three *_in_ready = alpha_in_valid & xmean_in_valid & xhatmean_in_valid (join). A partial set of valid inputs is not consumed.
  - When the join fires: latch the three data words, clear the three counters, go to EMIT.
- EMIT:
  - Each channel c has its own counter cnt_c, BLOCK_SIZE_LOG+1 bits.
  - c_valid = (cnt_c < N).
  - c_data = latched value, stable for the whole block.
  - c_last = (cnt_c == N-1).
  - A handshake on c increments cnt_c. A channel with cnt_c == N holds valid low while the others continue.
  - All *_in_ready=0 in EMIT.
  - When all three counters equal N (including the cycle where the final handshakes land simultaneously): next cycle state=LOAD and block_done pulses high for exactly that one cycle.
- Throughput: N+1 cycles minimum per block with all readies high (1 load cycle + N emit cycles).
- Latency: first output valid 1 cycle after the input join fires.
- Input data changing while in EMIT has no effect on the latched values.
- Back-pressure on any output only stalls that channel.
- No arithmetic on data; values pass through bit-exact.

Test Plan:
- Basic replay:
  - Stimulus: BLOCK_SIZE_LOG=2; inputs alpha=256, xmean=640, xhatmean=384; all readies high.
  - Required: each output emits exactly 4 beats of its value; *_last high on the 4th beat only; block_done pulse 1 cycle after the 4th beat; inputs then re-accepted.
- Partial input validity:
  - Stimulus: alpha and xmean valid; xhatmean valid low for 5 cycles.
  - Required: all *_in_ready stay 0 and no output valid during those cycles; the join fires on the cycle xhatmean_in_valid rises.
- Skewed drain:
  - Stimulus: alpha_ready held 0 for 10 cycles while the other two outputs are drained.
  - Required: xmean and xhatmean finish 4 beats each and drop valid; alpha then emits 4 beats; block_done fires only after the last alpha beat.
- Back-to-back blocks:
  - Stimulus: sources supply (256,640,384) then (257,896,896); all readies high.
  - Required: 4×first triple, then a one-cycle gap, then 4×second triple; total 10 cycles from the first join.
- Reset mid-block:
  - Stimulus: assert rst after the 2nd beat.
  - Required: all valids drop immediately (asynchronously); after release the block sits in LOAD with counters 0 and outputs nothing until a new triple is joined.
- Default size:
  - Stimulus: BLOCK_SIZE_LOG=8.
  - Required: exactly 256 beats per channel per block; *_last high only on beat 256.

Source files
------------

// File: rtl/nthband_param_sequencer.sv
// Per-block parameter scheduler for the nth-band predictor: joins one
// alpha/xmean/xhatmean triple, then replays each value 2^BLOCK_SIZE_LOG times.
module nthband_param_sequencer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ALPHA_WIDTH    = 10,
  parameter int unsigned BLOCK_SIZE_LOG = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alpha_in_valid,
  output logic                   alpha_in_ready,
  input  logic [ALPHA_WIDTH-1:0] alpha_in_data,
  input  logic                   xmean_in_valid,
  output logic                   xmean_in_ready,
  input  logic [DATA_WIDTH-1:0]  xmean_in_data,
  input  logic                   xhatmean_in_valid,
  output logic                   xhatmean_in_ready,
  input  logic [DATA_WIDTH-1:0]  xhatmean_in_data,
  output logic                   alpha_valid,
  input  logic                   alpha_ready,
  output logic [ALPHA_WIDTH-1:0] alpha_data,
  output logic                   alpha_last,
  output logic                   xmean_valid,
  input  logic                   xmean_ready,
  output logic [DATA_WIDTH-1:0]  xmean_data,
  output logic                   xmean_last,
  output logic                   xhatmean_valid,
  input  logic                   xhatmean_ready,
  output logic [DATA_WIDTH-1:0]  xhatmean_data,
  output logic                   xhatmean_last,
  output logic                   block_done
);

  localparam int unsigned     CW       = BLOCK_SIZE_LOG + 1;
  localparam logic [CW-1:0]   N_CNT    = CW'(1) << BLOCK_SIZE_LOG;
  localparam logic [CW-1:0]   LAST_CNT = N_CNT - CW'(1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt    [3];
  logic [CW-1:0]          cnt_nx [3];
  logic [2:0]             hs;
  logic [2:0]             valid_q;
  logic [2:0]             last_q;
  logic                   all_done;
  logic                   join_all;
  logic                   in_ready;
  logic [ALPHA_WIDTH-1:0] alpha_q;
  logic [DATA_WIDTH-1:0]  xmean_q;
  logic [DATA_WIDTH-1:0]  xhatmean_q;

  assign join_all = alpha_in_valid & xmean_in_valid & xhatmean_in_valid;
  // Gated by rst so no source sees ready while the block is held in reset.
  assign in_ready = (state == LOAD) & join_all & ~rst;

  assign alpha_in_ready    = in_ready;
  assign xmean_in_ready    = in_ready;
  assign xhatmean_in_ready = in_ready;

  assign hs = valid_q & {xhatmean_ready, xmean_ready, alpha_ready};

  always_comb begin
    all_done = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_nx[i] = cnt[i] + CW'(hs[i]);
      if (cnt_nx[i] != N_CNT) all_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
      valid_q    <= '0;
      last_q     <= '0;
      alpha_q    <= '0;
      xmean_q    <= '0;
      xhatmean_q <= '0;
      block_done <= 1'b0;
    end else begin
      block_done <= 1'b0;
      case (state)
        LOAD: begin
          if (join_all) begin
            alpha_q    <= alpha_in_data;
            xmean_q    <= xmean_in_data;
            xhatmean_q <= xhatmean_in_data;
            for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
            valid_q    <= '1;
            last_q     <= {3{LAST_CNT == '0}};
            state      <= EMIT;
          end
        end
        EMIT: begin
          // valid/last are registered from the next count so they stay glitch-free
          for (int unsigned i = 0; i < 3; i++) begin
            cnt[i]     <= cnt_nx[i];
            valid_q[i] <= (cnt_nx[i] < N_CNT);
            last_q[i]  <= (cnt_nx[i] == LAST_CNT);
          end
          if (all_done) begin
            state      <= LOAD;
            block_done <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign alpha_valid    = valid_q[0];
  assign xmean_valid    = valid_q[1];
  assign xhatmean_valid = valid_q[2];
  assign alpha_last     = last_q[0];
  assign xmean_last     = last_q[1];
  assign xhatmean_last  = last_q[2];
  assign alpha_data     = alpha_q;
  assign xmean_data     = xmean_q;
  assign xhatmean_data  = xhatmean_q;

endmodule

// File: tb/tb_nthband_param_sequencer.sv
// Randomized bench for nthband_param_sequencer: a remaining-beats model for an
// N=4 instance plus a beat-count check on a default-size (N=256) instance.
module tb_nthband_param_sequencer;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_iv, x_iv, h_iv, a_ir, x_ir, h_ir;
  logic [9:0] a_id;
  logic [15:0] x_id, h_id;
  logic       a_v, x_v, h_v, a_r, x_r, h_r, a_l, x_l, h_l, bdone;
  logic [9:0] a_d;
  logic [15:0] x_d, h_d;

  nthband_param_sequencer #(.DATA_WIDTH(16), .ALPHA_WIDTH(10), .BLOCK_SIZE_LOG(2)) dut (
    .clk(clk), .rst(rst),
    .alpha_in_valid(a_iv), .alpha_in_ready(a_ir), .alpha_in_data(a_id),
    .xmean_in_valid(x_iv), .xmean_in_ready(x_ir), .xmean_in_data(x_id),
    .xhatmean_in_valid(h_iv), .xhatmean_in_ready(h_ir), .xhatmean_in_data(h_id),
    .alpha_valid(a_v), .alpha_ready(a_r), .alpha_data(a_d), .alpha_last(a_l),
    .xmean_valid(x_v), .xmean_ready(x_r), .xmean_data(x_d), .xmean_last(x_l),
    .xhatmean_valid(h_v), .xhatmean_ready(h_r), .xhatmean_data(h_d), .xhatmean_last(h_l),
    .block_done(bdone)
  );

  logic        d_iv;
  logic        d_air, d_xir, d_hir;
  logic [9:0]  d_aid;
  logic [15:0] d_xid, d_hid;
  logic        d_av, d_xv, d_hv, d_al, d_xl, d_hl, d_rdy, d_done;
  logic [9:0]  d_ad;
  logic [15:0] d_xd, d_hd;

  nthband_param_sequencer #(.DATA_WIDTH(16), .ALPHA_WIDTH(10), .BLOCK_SIZE_LOG(8)) dut8 (
    .clk(clk), .rst(rst),
    .alpha_in_valid(d_iv), .alpha_in_ready(d_air), .alpha_in_data(d_aid),
    .xmean_in_valid(d_iv), .xmean_in_ready(d_xir), .xmean_in_data(d_xid),
    .xhatmean_in_valid(d_iv), .xhatmean_in_ready(d_hir), .xhatmean_in_data(d_hid),
    .alpha_valid(d_av), .alpha_ready(d_rdy), .alpha_data(d_ad), .alpha_last(d_al),
    .xmean_valid(d_xv), .xmean_ready(d_rdy), .xmean_data(d_xd), .xmean_last(d_xl),
    .xhatmean_valid(d_hv), .xhatmean_ready(d_rdy), .xhatmean_data(d_hd), .xhatmean_last(d_hl),
    .block_done(d_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: per channel, how many beats of the latched value are still owed.
  bit          busy;
  int          rem [3];
  logic [31:0] val [3];
  bit          done_exp;

  task automatic model_reset();
    busy = 0;
    done_exp = 0;
    for (int c = 0; c < 3; c++) begin
      rem[c] = 0;
      val[c] = '0;
    end
  endtask

  task automatic check_outputs();
    logic join_now;
    join_now = a_iv & x_iv & h_iv;
    check("a_in_ready", a_ir, !busy && join_now);
    check("x_in_ready", x_ir, !busy && join_now);
    check("h_in_ready", h_ir, !busy && join_now);
    check("a_valid", a_v, rem[0] > 0);
    check("x_valid", x_v, rem[1] > 0);
    check("h_valid", h_v, rem[2] > 0);
    check("a_last", a_l, rem[0] == 1);
    check("x_last", x_l, rem[1] == 1);
    check("h_last", h_l, rem[2] == 1);
    check("block_done", bdone, done_exp);
    if (rem[0] > 0) check("a_data", a_d, val[0]);
    if (rem[1] > 0) check("x_data", x_d, val[1]);
    if (rem[2] > 0) check("h_data", h_d, val[2]);
  endtask

  task automatic model_advance();
    logic [2:0] rdy;
    done_exp = 0;
    rdy = {h_r, x_r, a_r};
    if (!busy) begin
      if (a_iv && x_iv && h_iv) begin
        busy = 1;
        val[0] = 32'(a_id);
        val[1] = 32'(x_id);
        val[2] = 32'(h_id);
        for (int c = 0; c < 3; c++) rem[c] = N;
      end
    end else begin
      for (int c = 0; c < 3; c++)
        if (rem[c] > 0 && rdy[c]) rem[c]--;
      if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0) begin
        busy = 0;
        done_exp = 1;
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the next rising edge.
  task automatic step(input logic [2:0] iv, input logic [2:0] rdy,
                      input logic [9:0] a, input logic [15:0] x, input logic [15:0] h);
    a_iv = iv[0]; x_iv = iv[1]; h_iv = iv[2];
    a_id = a; x_id = x; h_id = h;
    a_r = rdy[0]; x_r = rdy[1]; h_r = rdy[2];
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input logic [2:0] iv, input logic [2:0] rdy);
    step(iv, rdy, 10'($urandom), 16'($urandom), 16'($urandom));
  endtask

  int bt [3];
  int blocks;
  logic [31:0] d_exp [3];

  task automatic d8_beat(input int c, input logic v, input logic l,
                         input logic [31:0] d);
    if (v && d_rdy) begin
      check("d8_last", l, bt[c] == 255);
      check("d8_data", d, d_exp[c]);
      bt[c]++;
    end
  endtask

  initial begin
    model_reset();
    a_iv = 0; x_iv = 0; h_iv = 0; a_id = '0; x_id = '0; h_id = '0;
    a_r = 0; x_r = 0; h_r = 0;
    d_iv = 0; d_rdy = 0; d_aid = '0; d_xid = '0; d_hid = '0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 0;

    // Basic replay
    step(3'b111, 3'b111, 10'd256, 16'd640, 16'd384);
    repeat (6) rstep(3'b000, 3'b111);

    // Back-to-back blocks; second triple offered during the first block
    step(3'b111, 3'b111, 10'd256, 16'd640, 16'd384);
    repeat (5) step(3'b111, 3'b111, 10'd257, 16'd896, 16'd896);
    repeat (5) rstep(3'b000, 3'b111);

    // Partial input validity, then join
    repeat (5) rstep(3'b011, 3'b111);
    rstep(3'b111, 3'b111);

    // Skewed drain: alpha stalled for 10 cycles
    repeat (10) rstep(3'b000, 3'b110);
    repeat (6) rstep(3'b000, 3'b111);

    // Reset mid-block after the 2nd beat
    rstep(3'b111, 3'b111);
    repeat (2) rstep(3'b000, 3'b111);
    rst = 1;
    #1;
    check("rst_a_valid", a_v, 1'b0);
    check("rst_x_valid", x_v, 1'b0);
    check("rst_h_valid", h_v, 1'b0);
    check("rst_in_ready", a_ir | x_ir | h_ir, 1'b0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    repeat (4) rstep(3'b000, 3'b111);
    rstep(3'b111, 3'b111);
    repeat (5) rstep(3'b000, 3'b111);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      rstep(3'($urandom), 3'($urandom));
    repeat (40) rstep(3'b000, 3'b111);

    // Default size: two full blocks of 256 beats
    d_aid = 10'($urandom);
    d_xid = 16'($urandom);
    d_hid = 16'($urandom);
    d_exp[0] = 32'(d_aid);
    d_exp[1] = 32'(d_xid);
    d_exp[2] = 32'(d_hid);
    for (int c = 0; c < 3; c++) bt[c] = 0;
    blocks = 0;
    d_iv = 1;
    d_rdy = 1;
    for (int cyc = 0; cyc < 700 && blocks < 2; cyc++) begin
      @(negedge clk);
      if (d_done) begin
        for (int c = 0; c < 3; c++) begin
          check("d8_beats", bt[c], 256);
          bt[c] = 0;
        end
        blocks++;
      end
      d8_beat(0, d_av, d_al, 32'(d_ad));
      d8_beat(1, d_xv, d_xl, 32'(d_xd));
      d8_beat(2, d_hv, d_hl, 32'(d_hd));
    end
    check("d8_blocks", blocks, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
